// File: rtl/cnn_pkg.sv
// cnn_pkg: shared controller state encoding and expected compute-cycle arithmetic
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_LD,
        COMPUTE,
        DRAIN,
        STORE,
        WAIT_ST,
        DONE
    } ctrl_state_e;

    function automatic logic [31:0] exp_cycles(input int unsigned n, input int unsigned m,
                                               input int unsigned k, input int unsigned r,
                                               input int unsigned c, input int unsigned tn,
                                               input int unsigned tm);
        return 32'(k * k * ((n + tn - 1) / tn) * ((m + tm - 1) / tm) * r * c);
    endfunction

endpackage

// File: rtl/cnn_delay_counter.sv
// cnn_delay_counter: loadable down-counter flagging the final cycle of a fixed-length hold
module cnn_delay_counter #(
    parameter int LEN_p = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic en_i,
    output logic last_o
);

    localparam int W = $clog2(LEN_p + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // load the hold length on entry, then count down while enabled and stop at zero
    always_comb begin
        cnt_d = load_i ? W'(LEN_p) : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end

    // counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign last_o = en_i && cnt_q == W'(1);

endmodule

// File: rtl/cnn_layer_ctrl.sv
// cnn_layer_ctrl: sequences load, compute, drain and store for one CNN layer and audits compute length
module cnn_layer_ctrl
    import cnn_pkg::*;
#(
    parameter int N_p     = 4,
    parameter int M_p     = 4,
    parameter int K_p     = 2,
    parameter int R_p     = 16,
    parameter int C_p     = 16,
    parameter int Tn_p    = 2,
    parameter int Tm_p    = 2,
    parameter int DRAIN_p = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_v_i,
    output logic        start_ready_o,
    output logic        load_req_o,
    input  logic        load_done_i,
    output logic        iter_reset_o,
    output logic        busy_o,
    input  logic        iter_done_i,
    output logic        store_req_o,
    input  logic        store_done_i,
    output logic        done_o,
    output logic [31:0] cycles_o,
    output logic        err_o
);

    localparam logic [31:0] EXP = exp_cycles(N_p, M_p, K_p, R_p, C_p, Tn_p, Tm_p);

    ctrl_state_e state_q, state_d;
    logic [31:0] cycles_q, cycles_d, cycles_inc;
    logic        err_q, err_d;
    logic        leave_compute, drain_last;

    assign leave_compute = state_q == COMPUTE && iter_done_i;
    assign cycles_inc    = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;

    cnn_delay_counter #(.LEN_p(DRAIN_p)) u_drain (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (leave_compute),
        .en_i   (state_q == DRAIN),
        .last_o (drain_last)
    );

    // next state, handshake outputs and cycle audit; reset forces the quiescent output set
    always_comb begin
        state_d       = state_q;
        start_ready_o = 1'b0;
        load_req_o    = 1'b0;
        iter_reset_o  = 1'b0;
        busy_o        = 1'b0;
        store_req_o   = 1'b0;
        done_o        = 1'b0;
        cycles_d      = cycles_q;
        err_d         = err_q | (leave_compute && cycles_inc != EXP);
        case (state_q)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_v_i) state_d = LOAD;
            end
            LOAD: begin
                load_req_o   = 1'b1;
                iter_reset_o = 1'b1;
                cycles_d     = '0;
                state_d      = WAIT_LD;
            end
            WAIT_LD: if (load_done_i) state_d = COMPUTE;
            COMPUTE: begin
                busy_o   = 1'b1;
                cycles_d = cycles_inc;
                if (iter_done_i) state_d = DRAIN;
            end
            DRAIN:   if (drain_last) state_d = STORE;
            STORE: begin
                store_req_o = 1'b1;
                state_d     = WAIT_ST;
            end
            WAIT_ST: if (store_done_i) state_d = DONE;
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset_i) begin
            start_ready_o = 1'b0;
            load_req_o    = 1'b0;
            iter_reset_o  = 1'b1;
            busy_o        = 1'b0;
            store_req_o   = 1'b0;
            done_o        = 1'b0;
        end
    end

    // state, cycle counter and sticky error registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cycles_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            err_q    <= err_d;
        end
    end

    assign cycles_o = reset_i ? '0 : cycles_q;
    assign err_o    = err_q && !reset_i;

endmodule

// File: tb/tb_cnn_layer_ctrl.sv
// tb_cnn_layer_ctrl: scoreboard bench with a responder environment for load, iterator and store
module tb_cnn_layer_ctrl;

    localparam int DRAIN = 3;
    localparam int EXP   = 2 * 2 * ((4 + 1) / 2) * ((4 + 1) / 2) * 16 * 16;

    typedef struct {
        int t_busy;
        int t_done;
        int len;
        int err;
    } exp_t;

    typedef struct {
        int ld;
        int st;
        int len;
    } cfg_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_v_i = 1'b0;
    logic        load_done_i = 1'b0;
    logic        iter_done_i = 1'b0;
    logic        store_done_i = 1'b0;
    logic        start_ready_o, load_req_o, iter_reset_o, busy_o, store_req_o, done_o, err_o;
    logic [31:0] cycles_o;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   err_m = 0;
    bit   spur_ld = 0, spur_st = 0, spur_it = 0;
    exp_t sb[$];
    cfg_t cfg_q[$];

    cnn_layer_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_v_i    (start_v_i),
        .start_ready_o(start_ready_o),
        .load_req_o   (load_req_o),
        .load_done_i  (load_done_i),
        .iter_reset_o (iter_reset_o),
        .busy_o       (busy_o),
        .iter_done_i  (iter_done_i),
        .store_req_o  (store_req_o),
        .store_done_i (store_done_i),
        .done_o       (done_o),
        .cycles_o     (cycles_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // cycle index shared by stimulus, environment and monitor
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // environment: tile loader, loop iterator and writeback engine answering the controller
    int ld_cnt = 0, st_cnt = 0, busy_cnt = 0, cur_len = EXP, cur_st = 0;
    always @(posedge clk) begin
        #2;
        load_done_i  = spur_ld;
        store_done_i = spur_st;
        if (reset_i) begin
            ld_cnt   = 0;
            st_cnt   = 0;
            busy_cnt = 0;
        end
        if (busy_o) begin
            busy_cnt++;
            iter_done_i = (busy_cnt == cur_len) | spur_it;
        end else begin
            busy_cnt    = 0;
            iter_done_i = spur_it;
        end
        if (load_req_o && cfg_q.size() != 0) begin
            cfg_t c;
            c       = cfg_q.pop_front();
            ld_cnt  = c.ld + 1;
            cur_len = c.len;
            cur_st  = c.st;
        end else if (ld_cnt > 0) begin
            ld_cnt--;
            if (ld_cnt == 0) load_done_i = 1'b1;
        end
        if (store_req_o) st_cnt = cur_st + 1;
        else if (st_cnt > 0) begin
            st_cnt--;
            if (st_cnt == 0) store_done_i = 1'b1;
        end
    end

    // monitor: on each done_o pop the expected layer and compare timing, count and error flag
    int busy_start = -1, busy_len = 0, ready_chk = -1;
    bit busy_prev = 0;
    always @(negedge clk) begin
        if (reset_i) begin
            busy_start = -1;
            busy_len   = 0;
            busy_prev  = 0;
            ready_chk  = -1;
        end else begin
            if (busy_o) begin
                if (!busy_prev) begin
                    busy_start = cyc;
                    busy_len   = 0;
                end
                busy_len++;
            end
            busy_prev = busy_o;
            if (cyc == ready_chk) chk("ready_after_done", start_ready_o, 1);
            if (done_o) begin
                if (sb.size() == 0) chk("unexpected_done", done_o, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_time", cyc, e.t_done);
                    chk("busy_start", busy_start, e.t_busy);
                    chk("busy_len", busy_len, e.len);
                    chk("cycles", cycles_o, e.len);
                    chk("err", err_o, e.err);
                end
                ready_chk = cyc + 1;
            end
        end
    end

    // expected layer: busy starts one cycle after load_done_i, done one cycle after store_done_i
    task automatic launch(input int ld, input int st, input int len, input int tl, output int td);
        exp_t e;
        cfg_q.push_back('{ld, st, len});
        err_m    = err_m | int'(len != EXP);
        e.t_busy = tl + 1 + (ld + 1);
        e.t_done = e.t_busy + len + DRAIN + 1 + (st + 1);
        e.len    = len;
        e.err    = err_m;
        sb.push_back(e);
        td = e.t_done;
    endtask

    task automatic single(input int ld, input int st, input int len);
        int td;
        start_v_i = 1'b1;
        launch(ld, st, len, cyc + 1, td);
        goto(cyc + 1);
        start_v_i = 1'b0;
        goto(td + 1);
        chk("layer_complete", sb.size(), 0);
        sb.delete();
    endtask

    task automatic b2b(input int n);
        int tl, td, last_tl;
        tl        = cyc + 1;
        last_tl   = tl;
        td        = tl;
        start_v_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            last_tl = tl;
            launch($urandom_range(0, 6), $urandom_range(0, 6), EXP, tl, td);
            tl = td + 2;
        end
        goto(last_tl);
        start_v_i = 1'b0;
        goto(td + 1);
        chk("b2b_complete", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", start_ready_o, 0);
        chk("rst_iter_reset", iter_reset_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_load_req", load_req_o, 0);
        chk("rst_store_req", store_req_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cycles", cycles_o, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", start_ready_o, 1);
        @(posedge clk);
        #1;
        spur_ld = 1;
        spur_st = 1;
        spur_it = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready", start_ready_o, 1);
            chk("idle_quiet", {busy_o, load_req_o, store_req_o, done_o, err_o}, 0);
            chk("idle_cycles", cycles_o, 0);
            @(posedge clk);
            #1;
            spur_ld = 0;
            spur_st = 0;
            spur_it = 0;
        end
        single(0, 0, EXP);
        single(10, 5, EXP);
        single(0, 0, 100);
        single(2, 1, EXP);
        begin
            int td, tb;
            start_v_i = 1'b1;
            launch(0, 0, EXP, cyc + 1, td);
            tb = sb[0].t_busy;
            goto(cyc + 1);
            start_v_i = 1'b0;
            goto(tb + 50);
            reset_i = 1'b1;
            sb.delete();
            err_m = 0;
            @(negedge clk);
            chk("midrst_busy", busy_o, 0);
            chk("midrst_iter_reset", iter_reset_o, 1);
            chk("midrst_ready", start_ready_o, 0);
            chk("midrst_quiet", {done_o, store_req_o, err_o}, 0);
            @(posedge clk);
            #1;
            reset_i = 1'b0;
            @(negedge clk);
            chk("postrst_ready", start_ready_o, 1);
            chk("postrst_busy", busy_o, 0);
            chk("postrst_cycles", cycles_o, 0);
            @(posedge clk);
            #1;
            goto(cyc + 20);
        end
        single(0, 0, EXP);
        b2b(3);
        for (int i = 0; i < 4; i++)
            single($urandom_range(0, 12), $urandom_range(0, 8),
                   $urandom_range(0, 1) != 0 ? EXP : $urandom_range(20, 300));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not reach the summary by cycle %0d", cyc);
        $fatal(1);
    end

endmodule
